// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for an N-input gate under test.
// Drives all input vectors, waits, compares, and reports the result.
module gate_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [N_IN:0] VEC_LAST =
    (N_IN+1)'((1 << N_IN) - 1);
  localparam logic [N_IN:0] VEC_ONE =
    (N_IN+1)'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t        state;
  state_t        state_nx;
  logic [N_IN:0] vec;
  logic [2:0]    mode_q;
  logic [3:0]    cnt;
  logic          accept;
  logic          base_y;
  logic          exp_y;
  logic          mis;
  logic          last_vec;

  assign accept   = start && (mode <= 3'd5);
  assign last_vec = (vec == VEC_LAST);
  assign mis      = (dut_y != exp_y);

  // Reference gate function for the latched mode.
  always_comb begin
    base_y = 1'b0;
    exp_y  = 1'b0;
    unique case (mode_q)
      3'd0, 3'd2: base_y = &dut_in;
      3'd1, 3'd3: base_y = |dut_in;
      3'd4, 3'd5: base_y = ^dut_in;
      default:    base_y = 1'b0;
    endcase
    exp_y = base_y ^ (mode_q == 3'd2 ||
                      mode_q == 3'd3 ||
                      mode_q == 3'd5);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = DRIVE;
      DRIVE: state_nx = WAIT;
      WAIT:  if (cnt <= 4'd1) state_nx = CHECK;
      CHECK: state_nx = last_vec ? DONE : DRIVE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sweep datapath, scoring and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      vec              <= '0;
      mode_q           <= 3'd0;
      cnt              <= 4'd0;
    end else begin
      busy <= (state_nx == DRIVE) ||
              (state_nx == WAIT)  ||
              (state_nx == CHECK);
      done <= (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            mode_q           <= mode;
            vec              <= '0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
          end
        end
        DRIVE: begin
          dut_in <= vec[N_IN-1:0];
          cnt    <= SETTLE_C;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
        end
        CHECK: begin
          if (mis) begin
            if (err_cnt != ERR_MAX)
              err_cnt <= err_cnt + 1'b1;
            if (!first_fail_valid) begin
              first_fail_vec   <= dut_in;
              first_fail_valid <= 1'b1;
            end
          end
          if (!last_vec) vec <= vec + VEC_ONE;
        end
        DONE: begin
          pass <= (err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-checking exhaustive sweep engine for an N-input combinational gate under test (GUT). It replaces hand-written per-gate stimulus sequences.
- It drives every input combination in ascending binary order and waits a programmable settle time. It then compares the GUT output against the expected function for the selected gate type and reports an error count, the first failing vector and a pass flag.
- It sits beside gate-level blocks in simulation and FPGA self-test builds.

Parameters:
- N_IN, 2, number of GUT inputs; legal 1..8.
- SETTLE, 1, cycles between driving a vector and sampling dut_y; legal 1..15.
- ERR_W, 8, width of error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled in IDLE only.
- mode  in  3  gate type: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 reserved.
- dut_in  out  N_IN  registered vector driven to the GUT inputs.
- dut_y  in  1  GUT output, combinational from dut_in.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  last sweep had zero mismatches.
- err_cnt  out  ERR_W  mismatch count; saturating.
- first_fail_vec  out  N_IN  first vector that mismatched.
- first_fail_valid  out  1  first_fail_vec holds a valid vector.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0, settle counter=0.
  - A reset mid-sweep aborts immediately. No done pulse is produced.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE:
  - On start=1 with mode<=5: latch mode_q=mode, vec=0, clear err_cnt, first_fail_valid and pass, then go to DRIVE.
  - start with mode 6 or 7 is ignored; all outputs hold.
- DRIVE (1 cycle): dut_in<=vec; load settle counter with SETTLE; go to WAIT.
- WAIT (SETTLE cycles): decrement the counter; go to CHECK when it expires.
- CHECK (1 cycle): exp = reduction op of dut_in per mode_q.
  - NAND/NOR/XNOR are the inversions of AND/OR/XOR.
  - If dut_y != exp:
    - err_cnt<=err_cnt+1, saturating at 2^ERR_W-1.
    - If first_fail_valid=0: first_fail_vec<=dut_in and first_fail_valid<=1.
  - If vec is all ones, go to DONE. Otherwise vec<=vec+1 and go to DRIVE.
- DONE (1 cycle):
  - done=1, pass<=(err_cnt==0 and no mismatch in final CHECK), go to IDLE.
  - pass, err_cnt and first_fail_* hold until the next accepted start or reset.
- busy:
  - Registered; high in DRIVE, WAIT and CHECK.
  - Low in IDLE and DONE.
- Latency: each vector takes SETTLE+2 cycles. done is high in the cycle beginning 2^N_IN*(SETTLE+2) edges after the edge that accepted start.
- mode and start changes while not in IDLE are ignored. A start asserted during DONE is not accepted; it takes effect only if still high in IDLE.
- dut_in holds its last vector after DONE until the next DRIVE or reset.
- Width rules:
  - The vec counter is N_IN+1 bits internally so the termination compare never wraps.
  - N_IN=1 degenerates correctly: 2 vectors.

Test Plan:
1. N_IN=2, SETTLE=1, mode=2 (NAND), bench drives dut_y=~&dut_in.
   - Required: dut_in sequence 00,01,10,11.
   - Required: done 12 edges after start; pass=1, err_cnt=0, first_fail_valid=0.
2. Same config, mode=2, bench drives dut_y=&dut_in (wrong gate).
   - Required: err_cnt=4, first_fail_vec=2'b00, first_fail_valid=1, pass=0.
3. Mode=2, dut_y stuck at 1.
   - Required: only vector 11 fails; err_cnt=1, first_fail_vec=2'b11, pass=0.
4. N_IN=3, SETTLE=3, mode=4 (XOR), correct model.
   - Required: 8 vectors; done 40 edges after start; pass=1.
5. N_IN=3, ERR_W=2, mode=1 (OR), dut_y stuck at 0.
   - Required: 7 mismatches saturate err_cnt=3; first_fail_vec=3'b001.
6. Control cases:
   - Assert rst_n=0 while dut_in=2'b10 mid-sweep: required is all outputs 0 asynchronously and no done pulse. A later start with mode=0 runs a clean sweep.
   - start pulsed while busy: no effect.
   - start with mode=6: busy stays 0 and no done pulse.
